sdram_read_to_avalon_st: RTL

Read-side counterpart of the SDRAM write path: accepts 32-bit byte-address instructions, issues fixed 8-beat 256-bit Avalon-MM read bursts to SDRAM, byte-reverses each returned beat and streams it out on an Avalon-ST source. A show-ahead FIFO absorbs returned beats, since `mm_readdatavalid` cannot be stalled while the stream sink can backpressure. It feeds the accelerator datapath from DRAM and exposes a small debug CSR.

---
 rtl/sdram_read_to_avalon_st.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sdram_read_to_avalon_st.sv
// SDRAM read path: takes byte-address instructions, issues 8-beat
// 256-bit Avalon-MM read bursts and streams byte-reversed beats on
// Avalon-ST through a show-ahead FIFO. Also exposes a small debug CSR.
//
// Ports:
//   clock, reset          sole clock, async active-high reset
//   mm_*                  Avalon-MM read master (burst word address)
//   st_instruction_*      instruction sink (data = byte address, 0 = no-op)
//   st_valid/data/ready   Avalon-ST beat source
//   csr_*                 registered debug readback
module sdram_read_to_avalon_st #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic         clock,
    input  logic         reset,
    output logic [26:0]  mm_addr,
    output logic [31:0]  mm_byteenable,
    output logic [7:0]   mm_burstcount,
    output logic         mm_read,
    input  logic [255:0] mm_readdata,
    input  logic         mm_readdatavalid,
    input  logic         mm_waitrequest,
    input  logic         st_instruction_valid,
    output logic         st_instruction_ready,
    input  logic [31:0]  st_instruction_data,
    output logic         st_valid,
    output logic [255:0] st_data,
    input  logic         st_ready,
    output logic [31:0]  csr_readdata,
    input  logic [3:0]   csr_address,
    input  logic         csr_read
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    // Highest fill level that still leaves room for a whole burst.
    localparam logic [CW-1:0] FILL_MAX = CW'(FIFO_DEPTH - 8);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQUEST   = 2'd1,
        RECEIVING = 2'd2
    } state_t;

    state_t        state;
    logic [3:0]    beat_count;
    logic [31:0]   bursts_done;

    logic [255:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;
    logic [255:0]  swapped;

    logic is_noop;
    logic take_cmd;
    logic push;
    logic pop;
    logic last_beat;
    logic unused_bits;

    assign is_noop  = st_instruction_data == 32'd0;
    assign take_cmd = (state == IDLE) && st_instruction_valid
                      && !is_noop && (fifo_count <= FILL_MAX);
    assign st_instruction_ready = take_cmd
                                  || (st_instruction_valid && is_noop);

    // Returned beats cannot be stalled; anything arriving in IDLE is stale.
    assign push      = mm_readdatavalid && (state != IDLE);
    assign pop       = st_valid && st_ready;
    assign last_beat = push && (beat_count == 4'd7);

    assign st_valid = fifo_count != '0;
    assign st_data  = mem[rd_ptr];

    assign unused_bits = &{1'b0, csr_read, st_instruction_data[4:0]};

    always_comb begin
        swapped = '0;
        for (int k = 0; k < 32; k++) begin
            swapped[8*k +: 8] = mm_readdata[8*(31-k) +: 8];
        end
    end

    // Storage carries no reset; validity is tracked by fifo_count.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= swapped;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            mm_addr       <= '0;
            mm_byteenable <= '0;
            mm_burstcount <= '0;
            mm_read       <= 1'b0;
            beat_count    <= '0;
            bursts_done   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_cmd) begin
                        mm_addr       <= st_instruction_data[31:5];
                        mm_byteenable <= 32'hFFFF_FFFF;
                        mm_burstcount <= 8'd8;
                        mm_read       <= 1'b1;
                        beat_count    <= '0;
                        state         <= REQUEST;
                    end
                end
                REQUEST: begin
                    if (!mm_waitrequest) begin
                        mm_read <= 1'b0;
                        state   <= RECEIVING;
                    end
                end
                default: ;
            endcase
            if (push) begin
                beat_count <= beat_count + 4'd1;
            end
            if (last_beat) begin
                state       <= IDLE;
                mm_read     <= 1'b0;
                bursts_done <= bursts_done + 32'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            csr_readdata <= '0;
        end else begin
            case (csr_address)
                4'd0:    csr_readdata <= {30'd0, state};
                4'd4:    csr_readdata <= bursts_done;
                4'd8:    csr_readdata <= {5'd0, mm_addr};
                4'd12:   csr_readdata <= {22'd0, mm_read, mm_waitrequest,
                                          mm_readdatavalid, 1'b0,
                                          st_instruction_valid,
                                          st_instruction_ready, 2'b0,
                                          st_valid, st_ready};
                4'd13:   csr_readdata <= {{(32-CW){1'b0}}, fifo_count};
                default: csr_readdata <= 32'hDEAD_BEEF;
            endcase
        end
    end
endmodule
